// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with period-boundary config handoff.
// Optional CLKDIV_SYNC_EN adds sync_in for phase alignment of several dividers.
module clk_div_prog #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 10,
  parameter int DEFAULT_HIGH = 5
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_err,
  output logic [WIDTH-1:0] count,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] high;
  logic [WIDTH-1:0] p_div;
  logic [WIDTH-1:0] p_high;
  logic [WIDTH-1:0] high_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             p_vld;
  logic             wrap;
  logic             accept;
  logic             bad_cfg;
  logic             sync_hit;
  logic             restart;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_in;
`else
  assign sync_hit = 1'b0;
`endif

  assign cfg_ready = !p_vld;
  assign accept    = cfg_valid && cfg_ready;
  assign bad_cfg   = cfg_div < TWO;
  assign wrap      = (count == div - ONE);
  assign count_nxt = count + ONE;
  // A held divider with a pending config restarts at once rather than waiting.
  assign restart   = sync_hit || (en && wrap) || (!en && p_vld);

  always_comb begin
    high_clamped = cfg_high;
    if (cfg_high == '0)
      high_clamped = ONE;
    else if (cfg_high >= cfg_div)
      high_clamped = cfg_div - ONE;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count   <= '0;
      clk_out <= 1'b1;
      tick    <= 1'b0;
      cfg_err <= 1'b0;
      div     <= DIV_RST;
      high    <= HIGH_RST;
      p_div   <= DIV_RST;
      p_high  <= HIGH_RST;
      p_vld   <= 1'b0;
    end else begin
      cfg_err <= accept && bad_cfg;
      tick    <= 1'b0;
      if (accept && !bad_cfg) begin
        p_vld  <= 1'b1;
        p_div  <= cfg_div;
        p_high <= high_clamped;
      end
      if (restart) begin
        count   <= '0;
        clk_out <= 1'b1;
        tick    <= sync_hit || en;
        if (p_vld) begin
          div   <= p_div;
          high  <= p_high;
          p_vld <= 1'b0;
        end
      end else if (en) begin
        count   <= count_nxt;
        clk_out <= count_nxt < high;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (sync tests when CLKDIV_SYNC_EN is defined).
module tb_clk_div_prog;
  logic       clk_in = 1'b0;
  logic       reset;
  logic       en;
  logic       sync_in;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       cfg_err;
  logic [7:0] count;
  logic       clk_out;
  logic       tick;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(10), .DEFAULT_HIGH(5)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
`ifdef CLKDIV_SYNC_EN
    .sync_in   (sync_in),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_err   (cfg_err),
    .count     (count),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk_in);
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  // Starting from count 0, run n enabled edges of a div/high period.
  task automatic run_period(input string tag, input int d, input int h, input int n);
    int c;
    for (int i = 1; i <= n; i++) begin
      edge1();
      c = i % d;
      check({tag, "_count"}, 32'(count), 32'(c));
      check({tag, "_clk"}, 32'(clk_out), (c < h) ? 32'd1 : 32'd0);
      check({tag, "_tick"}, 32'(tick), (c == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic offer(input int d, input int h);
    cfg_valid = 1'b1;
    cfg_div   = 8'(d);
    cfg_high  = 8'(h);
    edge1();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sync_in = 1'b0;
    cfg_valid = 1'b0; cfg_div = 8'd0; cfg_high = 8'd0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_clk", 32'(clk_out), 32'd1);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;
    en = 1'b1;

    run_period("dflt", 10, 5, 20);

    // 7/3 offered at count 2; the old 10/5 period completes first.
    adv(2);
    check("p2_pre_count", 32'(count), 32'd2);
    offer(7, 3);
    check("p2_acc_count", 32'(count), 32'd3);
    check("p2_acc_ready", 32'(cfg_ready), 32'd0);
    for (int j = 4; j <= 9; j++) begin
      edge1();
      check("p2_old_count", 32'(count), 32'(j));
      check("p2_old_clk", 32'(clk_out), (j < 5) ? 32'd1 : 32'd0);
      check("p2_old_ready", 32'(cfg_ready), 32'd0);
    end
    edge1();
    check("p2_wrap_count", 32'(count), 32'd0);
    check("p2_wrap_tick", 32'(tick), 32'd1);
    check("p2_wrap_ready", 32'(cfg_ready), 32'd1);
    run_period("p7", 7, 3, 14);

    // Reset with a pending config at count 6.
    offer(9, 4);
    check("rs_ready", 32'(cfg_ready), 32'd0);
    adv(5);
    check("rs_pre_count", 32'(count), 32'd6);
    #2 reset = 1'b1;
    #1;
    check("rs_count", 32'(count), 32'd0);
    check("rs_clk", 32'(clk_out), 32'd1);
    check("rs_tick", 32'(tick), 32'd0);
    check("rs_ready1", 32'(cfg_ready), 32'd1);
    #1 reset = 1'b0;
    run_period("rs_dflt", 10, 5, 20);

    // Rejected config.
    offer(1, 3);
    check("err_pulse", 32'(cfg_err), 32'd1);
    check("err_ready", 32'(cfg_ready), 32'd1);
    check("err_count", 32'(count), 32'd1);
    edge1();
    check("err_clear", 32'(cfg_err), 32'd0);
    adv(7);
    check("err_count9", 32'(count), 32'd9);
    edge1();
    check("err_wrap", 32'(count), 32'd0);
    check("err_wrap_tick", 32'(tick), 32'd1);

    // High time clamped to div-1.
    offer(6, 9);
    check("hi_ready", 32'(cfg_ready), 32'd0);
    adv(8);
    edge1();
    check("hi_wrap", 32'(count), 32'd0);
    check("hi_wrap_ready", 32'(cfg_ready), 32'd1);
    run_period("p6h5", 6, 5, 6);

    // Zero high time clamped to 1.
    offer(6, 0);
    check("lo_clk", 32'(clk_out), 32'd1);
    adv(4);
    edge1();
    check("lo_wrap", 32'(count), 32'd0);
    run_period("p6h1", 6, 1, 6);

    // Freeze at count 4, then apply a config while disabled.
    adv(4);
    en = 1'b0;
    for (int j = 0; j < 20; j++) begin
      edge1();
      check("hold_count", 32'(count), 32'd4);
      check("hold_clk", 32'(clk_out), 32'd0);
      check("hold_tick", 32'(tick), 32'd0);
    end
    offer(4, 2);
    check("dis_acc_count", 32'(count), 32'd4);
    check("dis_acc_ready", 32'(cfg_ready), 32'd0);
    edge1();
    check("dis_app_count", 32'(count), 32'd0);
    check("dis_app_clk", 32'(clk_out), 32'd1);
    check("dis_app_tick", 32'(tick), 32'd0);
    check("dis_app_ready", 32'(cfg_ready), 32'd1);
    en = 1'b1;
    run_period("p4", 4, 2, 8);

`ifdef CLKDIV_SYNC_EN
    adv(2);
    sync_in = 1'b1;
    edge1();
    sync_in = 1'b0;
    check("sync_count", 32'(count), 32'd0);
    check("sync_clk", 32'(clk_out), 32'd1);
    check("sync_tick", 32'(tick), 32'd1);
    adv(3);
    sync_in = 1'b1;
    edge1();
    sync_in = 1'b0;
    check("syncw_count", 32'(count), 32'd0);
    check("syncw_tick", 32'(tick), 32'd1);
    offer(7, 3);
    sync_in = 1'b1;
    edge1();
    sync_in = 1'b0;
    check("syncp_count", 32'(count), 32'd0);
    check("syncp_ready", 32'(cfg_ready), 32'd1);
    run_period("sync_p7", 7, 3, 7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
